// File: rtl/m72_video_timing.sv
// M72 board B video timing: pixel enable, HE/VE beam counters, sync/blank decode,
// scroll-latch strobes from CPU I/O writes, and vblank/raster interrupt requests.
module m72_video_timing #(
  parameter int unsigned H_TOTAL   = 512,
  parameter int unsigned V_TOTAL   = 284,
  parameter bit          RASTER_EN = 1'b1
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        IO_WR,
  input  logic [7:0]  IO_A,
  input  logic [1:0]  BYTE_SEL,
  input  logic [15:0] DIN,
  output logic        DCLK_EN,
  output logic [9:0]  HE,
  output logic [8:0]  VE,
  output logic        HBLK,
  output logic        VBLK,
  output logic        HS,
  output logic        VS,
  output logic        NL,
  output logic [1:0]  HSCK,
  output logic [1:0]  VSCK,
  output logic        INT_VBL,
  output logic        INT_RAS,
  input  logic [1:0]  INT_ACK
);

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 9;
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW:0]   V_TOT_X  = (VW + 1)'(V_TOTAL);
  localparam logic [VW-1:0] VBL_LINE = VW'(272);

  logic [1:0]    pre;
  logic [VW-1:0] ras;
  logic [VW-1:0] ve_nxt;
  logic          wrap;
  logic          wr;
  logic [7:0]    addr;
  logic          ras_ok;

  assign wrap   = DCLK_EN && (HE == H_LAST);
  assign ve_nxt = (VE == V_LAST) ? '0 : VE + VW'(1);
  assign wr     = IO_WR && BYTE_SEL[0];
  assign addr   = {IO_A[7:1], 1'b0};
  assign ras_ok = RASTER_EN && ({1'b0, ras} < V_TOT_X);

  // Blank/sync decode straight from the registered beam counters
  assign HBLK = (HE < 10'd64) || (HE >= 10'd448);
  assign HS   = (HE >= 10'd464) && (HE < 10'd496);
  assign VBLK = (VE < 9'd16) || (VE >= 9'd272);
  assign VS   = (VE >= 9'd274) && (VE < 9'd277);

  // Prescaler and beam counters; DCLK_EN is registered so it is high while pre==3
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      pre     <= '0;
      DCLK_EN <= 1'b0;
      HE      <= '0;
      VE      <= '0;
    end else begin
      pre     <= pre + 2'd1;
      DCLK_EN <= (pre == 2'd2);
      if (DCLK_EN) begin
        if (wrap) begin
          HE <= '0;
          VE <= ve_nxt;
        end else begin
          HE <= HE + HW'(1);
        end
      end
    end
  end

  // CPU port decode: one-cycle scroll strobes plus flip and raster registers
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      HSCK <= '0;
      VSCK <= '0;
      NL   <= 1'b0;
      ras  <= '0;
    end else begin
      VSCK <= {wr && (addr == 8'h84), wr && (addr == 8'h80)};
      HSCK <= {wr && (addr == 8'h86), wr && (addr == 8'h82)};
      if (wr && (addr == 8'h02)) NL <= DIN[2];
      if (wr && (addr == 8'h40)) ras[7:0] <= DIN[7:0];
      if (wr && (addr == 8'h42)) ras[8] <= DIN[0];
    end
  end

  // Level interrupt requests; a set on the same edge as an ack takes priority
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      INT_VBL <= 1'b0;
      INT_RAS <= 1'b0;
    end else begin
      if (wrap && (ve_nxt == VBL_LINE)) INT_VBL <= 1'b1;
      else if (INT_ACK[0])              INT_VBL <= 1'b0;
      if (wrap && ras_ok && (ve_nxt == ras)) INT_RAS <= 1'b1;
      else if (INT_ACK[1])                   INT_RAS <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m72_video_timing.sv
// Directed bench: full-width instance for horizontal timing, short-line instance
// (16 pixels/line) to reach vertical events, interrupts and frame wrap quickly.
module tb_m72_video_timing;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_wr;
  logic [7:0]  io_a;
  logic [1:0]  byte_sel;
  logic [15:0] din;
  logic [1:0]  int_ack;

  logic       h_dclk, h_hblk, h_vblk, h_hs, h_vs, h_nl, h_ivbl, h_iras;
  logic [9:0] h_he;
  logic [8:0] h_ve;
  logic [1:0] h_hsck, h_vsck;

  logic       v_dclk, v_hblk, v_vblk, v_hs, v_vs, v_nl, v_ivbl, v_iras;
  logic [9:0] v_he;
  logic [8:0] v_ve;
  logic [1:0] v_hsck, v_vsck;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  always #5 clk = ~clk;

  m72_video_timing dut_h (
    .CLK_32M(clk), .reset(reset), .IO_WR(io_wr), .IO_A(io_a), .BYTE_SEL(byte_sel),
    .DIN(din), .DCLK_EN(h_dclk), .HE(h_he), .VE(h_ve), .HBLK(h_hblk), .VBLK(h_vblk),
    .HS(h_hs), .VS(h_vs), .NL(h_nl), .HSCK(h_hsck), .VSCK(h_vsck),
    .INT_VBL(h_ivbl), .INT_RAS(h_iras), .INT_ACK(int_ack)
  );

  m72_video_timing #(.H_TOTAL(16), .V_TOTAL(284), .RASTER_EN(1'b1)) dut_v (
    .CLK_32M(clk), .reset(reset), .IO_WR(io_wr), .IO_A(io_a), .BYTE_SEL(byte_sel),
    .DIN(din), .DCLK_EN(v_dclk), .HE(v_he), .VE(v_ve), .HBLK(v_hblk), .VBLK(v_vblk),
    .HS(v_hs), .VS(v_vs), .NL(v_nl), .HSCK(v_hsck), .VSCK(v_vsck),
    .INT_VBL(v_ivbl), .INT_RAS(v_iras), .INT_ACK(int_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ncyc++;
    end
  endtask

  task automatic goto_edge(input int target);
    while (ncyc < target) tick(1);
  endtask

  task automatic io(input logic [7:0] a, input logic [1:0] bs, input logic [15:0] d);
    io_wr = 1'b1; io_a = a; byte_sel = bs; din = d;
    tick(1);
    io_wr = 1'b0; byte_sel = 2'b00;
  endtask

  initial begin
    reset = 1'b1; io_wr = 1'b0; io_a = '0; byte_sel = '0; din = '0; int_ack = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_he", 32'(h_he), 0);
    chk("rst_ve", 32'(h_ve), 0);
    chk("rst_dclk", 32'(h_dclk), 0);
    chk("rst_blank", {30'd0, h_hblk, h_vblk}, 32'h3);
    chk("rst_sync", {30'd0, h_hs, h_vs}, 0);
    chk("rst_misc", {26'd0, h_nl, h_ivbl, h_iras, h_hsck, 1'b0} | 32'(h_vsck), 0);

    reset = 1'b0;
    ncyc  = 0;
    tick(1); chk("dclk_e1", 32'(h_dclk), 0);
    tick(2); chk("dclk_e3", 32'(h_dclk), 1);
    chk("he_e3", 32'(h_he), 0);
    tick(1); chk("he_e4", 32'(h_he), 1);
    chk("dclk_e4", 32'(h_dclk), 0);

    goto_edge(252);  chk("hblk_63", 32'(h_hblk), 1);
    goto_edge(256);  chk("hblk_64", 32'(h_hblk), 0);
    goto_edge(1023); chk("vblk_15", 32'(v_vblk), 1);
    goto_edge(1024); chk("vblk_16", 32'(v_vblk), 0);
    chk("ve_16", 32'(v_ve), 16);
    goto_edge(1788); chk("hblk_447", 32'(h_hblk), 0);
    goto_edge(1792); chk("hblk_448", 32'(h_hblk), 1);
    goto_edge(1852); chk("hs_463", 32'(h_hs), 0);
    goto_edge(1856); chk("hs_464", 32'(h_hs), 1);
    goto_edge(1980); chk("hs_495", 32'(h_hs), 1);
    goto_edge(1984); chk("hs_496", 32'(h_hs), 0);
    goto_edge(2044); chk("he_511", 32'(h_he), 511);
    chk("ve_line0", 32'(h_ve), 0);
    goto_edge(2048); chk("he_wrap", 32'(h_he), 0);
    chk("ve_line1", 32'(h_ve), 1);

    chk("hsck_idle", 32'(h_hsck), 0);
    io(8'h86, 2'b01, 16'h1234); chk("hsck_86", 32'(h_hsck), 2);
    tick(1);                    chk("hsck_86_off", 32'(h_hsck), 0);
    io(8'h86, 2'b10, 16'h1234); chk("hsck_hi_lane", 32'(h_hsck), 0);
    io_wr = 1'b1; io_a = 8'h80; byte_sel = 2'b01;
    tick(1);                    chk("vsck_80", 32'(h_vsck), 1);
    io_a = 8'h84;
    tick(1);                    chk("vsck_84", 32'(h_vsck), 2);
    io_wr = 1'b0;
    tick(1);                    chk("vsck_off", 32'(h_vsck), 0);
    io(8'h81, 2'b01, 16'h0);    chk("vsck_a0_ignored", 32'(h_vsck), 1);
    io(8'h88, 2'b01, 16'hffff); chk("unlisted", {28'd0, h_hsck, h_vsck}, 0);
    chk("nl_before", 32'(h_nl), 0);
    io(8'h02, 2'b01, 16'h0004); chk("nl_set", 32'(h_nl), 1);
    io(8'h40, 2'b01, 16'h0064);

    goto_edge(6399); chk("ras_pre", 32'(v_iras), 0);
    goto_edge(6400); chk("ras_set", 32'(v_iras), 1);
    chk("ras_ve", 32'(v_ve), 100);
    chk("ras_he", 32'(v_he), 0);
    tick(1); chk("ras_hold", 32'(v_iras), 1);
    int_ack = 2'b10;
    tick(1); chk("ras_ack", 32'(v_iras), 0);
    int_ack = 2'b00;

    goto_edge(17407); chk("vbl_pre", 32'(v_ivbl), 0);
    chk("vblk_271", 32'(v_vblk), 0);
    goto_edge(17408); chk("vbl_set", 32'(v_ivbl), 1);
    chk("vblk_272", 32'(v_vblk), 1);
    chk("vbl_ve", 32'(v_ve), 272);
    int_ack = 2'b01;
    tick(1); chk("vbl_ack", 32'(v_ivbl), 0);
    int_ack = 2'b00;
    goto_edge(17535); chk("vs_273", 32'(v_vs), 0);
    goto_edge(17536); chk("vs_274", 32'(v_vs), 1);
    goto_edge(17727); chk("vs_276", 32'(v_vs), 1);
    goto_edge(17728); chk("vs_277", 32'(v_vs), 0);
    goto_edge(18175); chk("ve_283", 32'(v_ve), 283);
    goto_edge(18176); chk("frame_wrap", {v_he, 13'd0, v_ve}, 0);

    io(8'h40, 2'b01, 16'h0010);
    io(8'h42, 2'b01, 16'h0001);
    goto_edge(35583); chk("both_pre", {30'd0, v_ivbl, v_iras}, 0);
    int_ack = 2'b11;
    tick(1); chk("both_set_vs_ack", {30'd0, v_ivbl, v_iras}, 3);
    int_ack = 2'b00;
    tick(1); chk("both_hold", {30'd0, v_ivbl, v_iras}, 3);
    int_ack = 2'b10;
    tick(1); chk("ras_ack2", {30'd0, v_ivbl, v_iras}, 2);
    int_ack = 2'b00;
    io(8'h42, 2'b01, 16'h0001);
    io(8'h40, 2'b01, 16'h0010);
    tick(1); chk("no_retrigger", 32'(v_iras), 0);
    chk("no_retrigger_ve", 32'(v_ve), 272);

    goto_edge(45952); chk("mid_ve", 32'(v_ve), 150);
    chk("mid_vbl", 32'(v_ivbl), 1);
    chk("mid_nl", 32'(v_nl), 1);
    io(8'h82, 2'b01, 16'h0); chk("mid_hsck", 32'(v_hsck), 1);
    reset = 1'b1;
    #1;
    chk("arst_ve", 32'(v_ve), 0);
    chk("arst_he", 32'(v_he), 0);
    chk("arst_irq", {30'd0, v_ivbl, v_iras}, 0);
    chk("arst_nl", 32'(v_nl), 0);
    chk("arst_hsck", 32'(v_hsck), 0);
    chk("arst_dclk", 32'(h_dclk), 0);
    chk("arst_h_he", 32'(h_he), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
